dpc_ctrl: RTL and testbench

Frame sequencer for the defect-pixel-correction line-buffer datapath. It accepts a raster pixel stream with a valid/ready handshake and drives the datapath shift enable. It tracks the position of the pixel currently in the centre of the 5x5 window (2 lines + 2 pixels behind the newest input) and flags border pixels that must bypass correction. After the last pixel of a frame it inserts flush shifts so every frame pixel reaches the output, then returns to idle.

---
 rtl/dpc_ctrl.sv | 151 +++++++++++++++
 tb/tb_dpc_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dpc_ctrl.sv
// Frame sequencer for the defect-pixel-correction line buffer: drives the datapath shift
// enable, tracks the window-centre pixel position, flags border bypass and flushes the frame tail.
module dpc_ctrl #(
    parameter int H   = 720,
    parameter int V   = 480,
    parameter int LAT = 2*H+2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_en,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic                 in_ready,
    output logic                 sft_en,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic [$clog2(V)-1:0] out_row,
    output logic [$clog2(H)-1:0] out_col,
    output logic                 dp_bypass,
    output logic                 busy,
    output logic                 err_sof
);
    localparam int RW  = $clog2(V);
    localparam int CLW = $clog2(H);
    localparam int NW  = $clog2(H*V+LAT+1);

    localparam logic [NW-1:0]  N_ONE     = NW'(1);
    localparam logic [NW-1:0]  N_LAT     = NW'(LAT);
    localparam logic [NW-1:0]  N_LASTPIX = NW'(H*V-1);
    localparam logic [NW-1:0]  N_END     = NW'(H*V+LAT-1);
    localparam logic [RW-1:0]  R_ONE     = RW'(1);
    localparam logic [RW-1:0]  R_LO      = RW'(2);
    localparam logic [RW-1:0]  R_HI      = RW'(V-2);
    localparam logic [CLW-1:0] C_ONE     = CLW'(1);
    localparam logic [CLW-1:0] C_LO      = CLW'(2);
    localparam logic [CLW-1:0] C_HI      = CLW'(H-2);
    localparam logic [CLW-1:0] C_LAST    = CLW'(H-1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t         state_q, state_d;
    logic [NW-1:0]  in_cnt_q, in_cnt_d;
    logic [NW-1:0]  shift_cnt_q, shift_cnt_d;
    logic           en_lat_q, en_lat_d;
    logic           out_valid_q, out_sof_q, out_eol_q, out_eof_q, dp_bypass_q, err_sof_q;
    logic [RW-1:0]  out_row_q, row_d;
    logic [CLW-1:0] out_col_q, col_d;
    logic           acc, produce, first_out, bypass;

    assign in_ready  = (state_q != FLUSH);
    assign acc       = in_valid & in_ready;
    assign sft_en    = (acc & (state_q != IDLE)) | (acc & in_sof & (state_q == IDLE))
                     | (state_q == FLUSH);
    assign busy      = (state_q != IDLE);
    // A shift emits a frame pixel once the first input has travelled LAT positions.
    assign produce   = sft_en & (state_q != IDLE) & (shift_cnt_q >= N_LAT);
    assign first_out = (shift_cnt_q == N_LAT);

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        shift_cnt_d = shift_cnt_q;
        en_lat_d    = en_lat_q;
        case (state_q)
            IDLE: if (acc && in_sof) begin
                en_lat_d    = cfg_en;
                in_cnt_d    = N_ONE;
                shift_cnt_d = N_ONE;
                state_d     = FILL;
            end
            FILL: if (acc) begin
                in_cnt_d    = in_cnt_q + N_ONE;
                shift_cnt_d = shift_cnt_q + N_ONE;
                if (shift_cnt_q == N_LAT) state_d = RUN;
            end
            RUN: if (acc) begin
                in_cnt_d    = in_cnt_q + N_ONE;
                shift_cnt_d = shift_cnt_q + N_ONE;
                if (in_cnt_q == N_LASTPIX) state_d = FLUSH;
            end
            FLUSH: begin
                shift_cnt_d = shift_cnt_q + N_ONE;
                if (shift_cnt_q == N_END) begin
                    state_d     = IDLE;
                    in_cnt_d    = '0;
                    shift_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Raster position of the pixel being emitted, kept as wrap counters.
    always_comb begin
        row_d = out_row_q;
        col_d = out_col_q;
        if (first_out) begin
            row_d = '0;
            col_d = '0;
        end else if (out_col_q == C_LAST) begin
            col_d = '0;
            row_d = out_row_q + R_ONE;
        end else begin
            col_d = out_col_q + C_ONE;
        end
        bypass = ~en_lat_q | (row_d < R_LO) | (row_d >= R_HI) | (col_d < C_LO) | (col_d >= C_HI);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            shift_cnt_q <= '0;
            en_lat_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            dp_bypass_q <= 1'b0;
            err_sof_q   <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            shift_cnt_q <= shift_cnt_d;
            en_lat_q    <= en_lat_d;
            out_valid_q <= produce;
            out_sof_q   <= produce & first_out;
            out_eol_q   <= produce & (col_d == C_LAST);
            out_eof_q   <= produce & (shift_cnt_q == N_END);
            dp_bypass_q <= produce & bypass;
            err_sof_q   <= acc & in_sof & ((state_q == FILL) || (state_q == RUN));
            if (produce) begin
                out_row_q <= row_d;
                out_col_q <= col_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign dp_bypass = dp_bypass_q;
    assign err_sof   = err_sof_q;
endmodule

// File: tb/tb_dpc_ctrl.sv
// Directed bench for dpc_ctrl at H=8, V=6: frame sequencing, positions, bypass, errors, reset.
module tb_dpc_ctrl;
    localparam int H    = 8;
    localparam int V    = 6;
    localparam int LAT  = 2*H+2;
    localparam int NPIX = H*V;

    logic       clk = 1'b0, rstn = 1'b0, cfg_en = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
    logic       in_ready, sft_en, out_valid, out_sof, out_eol, out_eof, dp_bypass, busy, err_sof;
    logic [2:0] out_row, out_col;
    int         n_chk = 0, n_err = 0;

    dpc_ctrl #(.H(H), .V(V), .LAT(LAT)) dut (
        .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready), .sft_en(sft_en), .out_valid(out_valid), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof), .out_row(out_row), .out_col(out_col),
        .dp_bypass(dp_bypass), .busy(busy), .err_sof(err_sof)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one frame (bub = bubble percentage) and checks every cycle against the raster model.
    task automatic run_frame(input int bub, input bit cfg, input int stray, input int abort_at);
        int pix = 0, k = 0, flush_left = 0, cyc = 0, nlow = 0, nbyp0 = 0, nerrp = 0;
        int r, c;
        bit acc, prod, sofd, exp_byp;
        while (!(pix == NPIX && flush_left == 0) && cyc < 1000) begin
            cyc++;
            if (pix == abort_at) begin
                in_valid = 1'b0; in_sof = 1'b0; rstn = 1'b0;
                #1;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_in_ready", in_ready, 1);
                chk("abort_sft_en", sft_en, 0);
                chk("abort_row_col", {out_row, out_col}, 0);
                chk("abort_flags", {out_sof, out_eol, out_eof, dp_bypass, err_sof}, 0);
                @(negedge clk); rstn = 1'b1;
                @(posedge clk); #1;
                return;
            end
            in_valid = (pix < NPIX) && ($urandom_range(0, 99) >= bub);
            in_sof   = in_valid && (pix == 0 || pix == stray);
            cfg_en   = cfg;
            #1;
            chk("in_ready", in_ready, flush_left == 0);
            chk("sft_en", sft_en, (in_valid && flush_left == 0) || flush_left > 0);
            if (!in_ready) nlow++;
            acc  = in_valid && flush_left == 0;
            sofd = acc && in_sof && pix != 0;
            prod = (acc && pix >= LAT) || flush_left > 0;
            @(posedge clk); #1;
            if (flush_left > 0) flush_left--;
            if (acc) begin
                pix++;
                if (pix == NPIX) flush_left = LAT;
            end
            chk("out_valid", out_valid, prod);
            chk("err_sof", err_sof, sofd);
            chk("busy", busy, pix > 0 && !(pix == NPIX && flush_left == 0));
            nerrp += int'(err_sof);
            if (prod) begin
                r = k / H; c = k % H;
                exp_byp = !cfg || r < 2 || r >= V-2 || c < 2 || c >= H-2;
                chk("out_row", out_row, r);
                chk("out_col", out_col, c);
                chk("out_sof", out_sof, k == 0);
                chk("out_eol", out_eol, c == H-1);
                chk("out_eof", out_eof, k == NPIX-1);
                chk("dp_bypass", dp_bypass, exp_byp);
                if (!dp_bypass) nbyp0++;
                k++;
            end
        end
        chk("cycle_budget", cyc < 1000, 1);
        chk("beat_count", k, NPIX);
        chk("ready_low_cycles", nlow, LAT);
        chk("bypass0_count", nbyp0, cfg ? (H-4)*(V-4) : 0);
        chk("err_sof_pulses", nerrp, stray > 0 ? 1 : 0);
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sft_en", sft_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {out_sof, out_eol, out_eof, dp_bypass, err_sof}, 0);
        chk("rst_row_col", {out_row, out_col}, 0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Pixels without SOF while idle are swallowed.
        repeat (5) begin
            in_valid = 1'b1; in_sof = 1'b0;
            #1;
            chk("idle_in_ready", in_ready, 1);
            chk("idle_sft_en", sft_en, 0);
            @(posedge clk); #1;
            chk("idle_busy", busy, 0);
            chk("idle_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;

        run_frame(0, 1'b1, -1, -1);   // continuous, correction on
        run_frame(30, 1'b1, -1, -1);  // random bubbles
        run_frame(0, 1'b0, -1, -1);   // correction off: all bypass
        run_frame(0, 1'b1, 20, -1);   // stray SOF on pixel 20
        run_frame(0, 1'b1, -1, 30);   // reset mid-RUN
        run_frame(0, 1'b1, -1, -1);   // clean frame after abort

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
